// File: rtl/nv_nvdla_cdma_sreg_pkg.sv
// Shared constants for the CDMA single register block: CSB offsets, field positions, reset values.
package nv_nvdla_cdma_sreg_pkg;

  localparam logic [11:0] SREG_OFF_STATUS   = 12'h000;
  localparam logic [11:0] SREG_OFF_POINTER  = 12'h004;
  localparam logic [11:0] SREG_OFF_ARB_ALS  = 12'h008;
  localparam logic [11:0] SREG_OFF_FLUSH    = 12'h00C;
  localparam logic [11:0] SREG_OFF_ERR      = 12'h010;
  localparam logic [11:0] SREG_OFF_ARB_CTRL = 12'h014;
  localparam logic [11:0] SREG_OFF_ARB_BASE = 12'h020;

  localparam int SREG_PTR_CONS_LSB = 16;
  localparam int SREG_ARB_WMB_LSB  = 16;
  localparam int SREG_ERR_OFF_LSB  = 16;

  localparam int SREG_FLUSH_DONE_BIT   = 0;
  localparam int SREG_FLUSH_REQ_BIT    = 1;
  localparam int SREG_FLUSH_STICKY_BIT = 2;
  localparam int SREG_ERR_RO_BIT       = 0;
  localparam int SREG_ERR_INV_BIT      = 1;

  localparam logic [11:0] SREG_WMB_RST = 12'd3;

  function automatic logic [11:0] sreg_arb_offset(input int k);
    return SREG_OFF_ARB_BASE + 12'(4 * k);
  endfunction

endpackage

// File: rtl/nv_nvdla_cdma_sreg_arb_shadow.sv
// Per-channel arbiter weight/wmb shadow and live registers; shadows are copied to live while the arbiter is idle.
module nv_nvdla_cdma_sreg_arb_shadow
  import nv_nvdla_cdma_sreg_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int W_WEIGHT = 4
) (
  input  logic                         nvdla_core_clk,
  input  logic                         nvdla_core_rstn,
  input  logic [NUM_CH-1:0]            wr_sel,
  input  logic [W_WEIGHT-1:0]          wr_weight,
  input  logic [W_WEIGHT-1:0]          wr_wmb,
  input  logic                         arb_idle,
  output logic [NUM_CH*W_WEIGHT-1:0]   shadow_weight,
  output logic [NUM_CH*W_WEIGHT-1:0]   shadow_wmb,
  output logic [NUM_CH*W_WEIGHT-1:0]   arb_weight,
  output logic [NUM_CH*W_WEIGHT-1:0]   arb_wmb,
  output logic                         pending
);

  localparam logic [W_WEIGHT-1:0] WMB_RST = W_WEIGHT'(SREG_WMB_RST);

  logic [NUM_CH*W_WEIGHT-1:0] shadow_weight_r;
  logic [NUM_CH*W_WEIGHT-1:0] shadow_wmb_r;
  logic [NUM_CH*W_WEIGHT-1:0] live_weight_r;
  logic [NUM_CH*W_WEIGHT-1:0] live_wmb_r;
  logic                       pending_r;
  logic                       apply_s;

  assign apply_s = pending_r & arb_idle;

  // Live takes the pre-edge shadow, so a write landing on the apply edge stays pending for the next one.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      shadow_weight_r <= '1;
      shadow_wmb_r    <= {NUM_CH{WMB_RST}};
      live_weight_r   <= '1;
      live_wmb_r      <= {NUM_CH{WMB_RST}};
      pending_r       <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_sel[k]) begin
          shadow_weight_r[k*W_WEIGHT +: W_WEIGHT] <= wr_weight;
          shadow_wmb_r[k*W_WEIGHT +: W_WEIGHT]    <= wr_wmb;
        end
      end
      if (apply_s) begin
        live_weight_r <= shadow_weight_r;
        live_wmb_r    <= shadow_wmb_r;
      end
      pending_r <= (|wr_sel) | (pending_r & ~arb_idle);
    end
  end

  assign shadow_weight = shadow_weight_r;
  assign shadow_wmb    = shadow_wmb_r;
  assign arb_weight    = live_weight_r;
  assign arb_wmb       = live_wmb_r;
  assign pending       = pending_r;

endmodule

// File: rtl/nv_nvdla_cdma_single_reg_v2.sv
// CDMA single register block: CSB decode, pointer, flush handshake, sticky W1C errors, irq, shadowed arbiter weights.
// Define NVDLA_CDMA_SREG_RDPIPE_EN to register reg_rd_data (one-cycle read latency); default is combinational.
module nv_nvdla_cdma_single_reg_v2
  import nv_nvdla_cdma_sreg_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          W_WEIGHT  = 4,
  parameter int          PTR_W     = 1,
  parameter int          NUM_GRP   = 2,
  parameter logic [11:0] BASE_ADDR = 12'h000
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  input  logic [11:0]                reg_offset,
  input  logic                       reg_wr_en,
  input  logic [31:0]                reg_wr_data,
  output logic [31:0]                reg_rd_data,
  input  logic [2*NUM_GRP-1:0]       status,
  input  logic [PTR_W-1:0]           consumer,
  input  logic                       flush_done,
  input  logic                       arb_idle,
  output logic [NUM_CH*W_WEIGHT-1:0] arb_weight,
  output logic [NUM_CH*W_WEIGHT-1:0] arb_wmb,
  output logic [PTR_W-1:0]           producer,
  output logic                       flush_req,
  output logic                       irq
);

  logic [11:0]                off_rel_s;
  logic                       hit_status_s, hit_ptr_s, hit_alias_s, hit_flush_s, hit_err_s, hit_ctrl_s;
  logic [NUM_CH-1:0]          arb_hit_s;
  logic [NUM_CH-1:0]          arb_wr_s;
  logic                       mapped_s, inv_set_s, ro_set_s, wr_ptr_s, wr_flush_s, wr_err_s;
  logic                       flush_rise_s, flush_set_s, done_clr_s;
  logic [NUM_CH*W_WEIGHT-1:0] shadow_weight_s, shadow_wmb_s;
  logic                       pending_s;
  logic [31:0]                arb_rd_s, rd_mux_s;
  logic                       unused_wr_data_s;

  logic [PTR_W-1:0] producer_r;
  logic             flush_req_r, flush_done_q_r, done_sticky_r, ro_wr_r, inv_wr_r, irq_r;
  logic [11:0]      bad_off_r;

  assign off_rel_s    = reg_offset - BASE_ADDR;
  assign hit_status_s = (off_rel_s == SREG_OFF_STATUS);
  assign hit_ptr_s    = (off_rel_s == SREG_OFF_POINTER);
  assign hit_alias_s  = (off_rel_s == SREG_OFF_ARB_ALS);
  assign hit_flush_s  = (off_rel_s == SREG_OFF_FLUSH);
  assign hit_err_s    = (off_rel_s == SREG_OFF_ERR);
  assign hit_ctrl_s   = (off_rel_s == SREG_OFF_ARB_CTRL);

  // Per-channel arbiter register hits.
  always_comb begin
    arb_hit_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_hit_s[k] = (off_rel_s == sreg_arb_offset(k));
    end
  end

  // Arbiter write selects; the 0x08 alias targets channel 0.
  always_comb begin
    arb_wr_s = '0;
    if (reg_wr_en) begin
      arb_wr_s    = arb_hit_s;
      arb_wr_s[0] = arb_hit_s[0] | hit_alias_s;
    end else begin
      arb_wr_s = '0;
    end
  end

  assign mapped_s   = hit_status_s | hit_ptr_s | hit_alias_s | hit_flush_s | hit_err_s | hit_ctrl_s | (|arb_hit_s);
  assign ro_set_s   = reg_wr_en & hit_status_s;
  assign inv_set_s  = reg_wr_en & ~mapped_s;
  assign wr_ptr_s   = reg_wr_en & hit_ptr_s;
  assign wr_flush_s = reg_wr_en & hit_flush_s;
  assign wr_err_s   = reg_wr_en & hit_err_s;

  assign flush_rise_s = flush_done & ~flush_done_q_r;
  assign flush_set_s  = wr_flush_s & reg_wr_data[SREG_FLUSH_REQ_BIT];
  assign done_clr_s   = wr_flush_s & reg_wr_data[SREG_FLUSH_STICKY_BIT];
  assign unused_wr_data_s = ^reg_wr_data;

  // Pointer, flush handshake, sticky event/error bits and irq; hardware sets win over software clears.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      producer_r     <= '0;
      flush_req_r    <= 1'b0;
      flush_done_q_r <= 1'b0;
      done_sticky_r  <= 1'b0;
      ro_wr_r        <= 1'b0;
      inv_wr_r       <= 1'b0;
      bad_off_r      <= 12'd0;
      irq_r          <= 1'b0;
    end else begin
      flush_done_q_r <= flush_done;
      producer_r     <= wr_ptr_s ? reg_wr_data[PTR_W-1:0] : producer_r;
      flush_req_r    <= flush_set_s ? 1'b1 : (flush_rise_s ? 1'b0 : flush_req_r);
      done_sticky_r  <= flush_rise_s ? 1'b1 : (done_clr_s ? 1'b0 : done_sticky_r);
      ro_wr_r        <= ro_set_s ? 1'b1 : ((wr_err_s & reg_wr_data[SREG_ERR_RO_BIT]) ? 1'b0 : ro_wr_r);
      inv_wr_r       <= inv_set_s ? 1'b1 : ((wr_err_s & reg_wr_data[SREG_ERR_INV_BIT]) ? 1'b0 : inv_wr_r);
      bad_off_r      <= (ro_set_s | inv_set_s) ? reg_offset : bad_off_r;
      irq_r          <= done_sticky_r | ro_wr_r | inv_wr_r;
    end
  end

  nv_nvdla_cdma_sreg_arb_shadow #(
    .NUM_CH   (NUM_CH),
    .W_WEIGHT (W_WEIGHT)
  ) u_arb_shadow (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .wr_sel          (arb_wr_s),
    .wr_weight       (reg_wr_data[W_WEIGHT-1:0]),
    .wr_wmb          (reg_wr_data[SREG_ARB_WMB_LSB +: W_WEIGHT]),
    .arb_idle        (arb_idle),
    .shadow_weight   (shadow_weight_s),
    .shadow_wmb      (shadow_wmb_s),
    .arb_weight      (arb_weight),
    .arb_wmb         (arb_wmb),
    .pending         (pending_s)
  );

  // Arbiter register readback returns the shadow copy.
  always_comb begin
    arb_rd_s = 32'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      arb_rd_s = arb_rd_s | (arb_hit_s[k] ?
                 ((32'(shadow_wmb_s[k*W_WEIGHT +: W_WEIGHT]) << SREG_ARB_WMB_LSB) |
                  32'(shadow_weight_s[k*W_WEIGHT +: W_WEIGHT])) : 32'd0);
    end
  end

  // Read mux; unmapped offsets fall through to the arbiter term, which is zero when nothing hits.
  always_comb begin
    rd_mux_s = 32'd0;
    case (off_rel_s)
      SREG_OFF_STATUS:   rd_mux_s = 32'(status);
      SREG_OFF_POINTER:  rd_mux_s = (32'(consumer) << SREG_PTR_CONS_LSB) | 32'(producer_r);
      SREG_OFF_ARB_ALS:  rd_mux_s = (32'(shadow_wmb_s[W_WEIGHT-1:0]) << SREG_ARB_WMB_LSB) |
                                    32'(shadow_weight_s[W_WEIGHT-1:0]);
      SREG_OFF_FLUSH:    rd_mux_s = {29'd0, done_sticky_r, flush_req_r, flush_done};
      SREG_OFF_ERR:      rd_mux_s = (32'(bad_off_r) << SREG_ERR_OFF_LSB) | {30'd0, inv_wr_r, ro_wr_r};
      SREG_OFF_ARB_CTRL: rd_mux_s = {31'd0, pending_s};
      default:           rd_mux_s = arb_rd_s;
    endcase
  end

`ifdef NVDLA_CDMA_SREG_RDPIPE_EN
  logic [31:0] rd_data_r;

  // Registered read data, valid the cycle after the offset is presented.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rd_data_r <= 32'd0;
    end else begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign reg_rd_data = rd_data_r;
`else
  assign reg_rd_data = rd_mux_s;
`endif

  assign producer  = producer_r;
  assign flush_req = flush_req_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_nv_nvdla_cdma_single_reg_v2.sv
// Self-checking bench for nv_nvdla_cdma_single_reg_v2: directed steps plus randomized traffic against a register-level model.
module tb_nv_nvdla_cdma_single_reg_v2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] off;
  logic        wr_en;
  logic [31:0] wdata, rdata;
  logic [3:0]  status;
  logic [0:0]  consumer;
  logic        flush_done, arb_idle;
  logic [7:0]  arb_weight, arb_wmb;
  logic [0:0]  producer;
  logic        flush_req, irq;

  always #5 clk = ~clk;

  nv_nvdla_cdma_single_reg_v2 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .reg_offset      (off),
    .reg_wr_en       (wr_en),
    .reg_wr_data     (wdata),
    .reg_rd_data     (rdata),
    .status          (status),
    .consumer        (consumer),
    .flush_done      (flush_done),
    .arb_idle        (arb_idle),
    .arb_weight      (arb_weight),
    .arb_wmb         (arb_wmb),
    .producer        (producer),
    .flush_req       (flush_req),
    .irq             (irq)
  );

  int checks = 0;
  int errors = 0;

  // Register-level reference state
  int m_sw[2], m_sm[2], m_lw[2], m_lm[2];
  int m_prod, m_bad;
  bit m_pend, m_freq, m_done, m_ro, m_inv, m_irq, m_fdq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sw[k] = 15; m_lw[k] = 15; m_sm[k] = 3; m_lm[k] = 3;
    end
    m_prod = 0; m_bad = 0;
    m_pend = 0; m_freq = 0; m_done = 0; m_ro = 0; m_inv = 0; m_irq = 0; m_fdq = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] o);
    case (o)
      12'h000: return {28'd0, status};
      12'h004: return (32'(consumer) << 16) | 32'(m_prod);
      12'h008: return 32'((m_sm[0] << 16) | m_sw[0]);
      12'h00C: return {29'd0, m_done, m_freq, flush_done};
      12'h010: return 32'((m_bad << 16) | (int'(m_inv) << 1) | int'(m_ro));
      12'h014: return {31'd0, m_pend};
      12'h020: return 32'((m_sm[0] << 16) | m_sw[0]);
      12'h024: return 32'((m_sm[1] << 16) | m_sw[1]);
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of register behaviour given this cycle's inputs.
  task automatic model_edge(input bit wr, input logic [11:0] o, input logic [31:0] d);
    bit rise;
    int ch;
    rise  = flush_done & ~m_fdq;
    m_fdq = flush_done;
    m_irq = m_done | m_ro | m_inv;
    if (m_pend && arb_idle) begin
      m_lw = m_sw; m_lm = m_sm; m_pend = 0;
    end
    if (rise) begin
      m_freq = 0; m_done = 1;
    end
    if (wr) begin
      ch = -1;
      case (o)
        12'h000: begin m_ro = 1; m_bad = int'(o); end
        12'h004: m_prod = int'(d[0]);
        12'h008: ch = 0;
        12'h00C: begin
          if (d[1]) m_freq = 1;
          if (d[2] && !rise) m_done = 0;
        end
        12'h010: begin
          if (d[0]) m_ro = 0;
          if (d[1]) m_inv = 0;
        end
        12'h014: ;
        12'h020: ch = 0;
        12'h024: ch = 1;
        default: begin m_inv = 1; m_bad = int'(o); end
      endcase
      if (ch >= 0) begin
        m_sw[ch] = int'(d[3:0]); m_sm[ch] = int'(d[19:16]); m_pend = 1;
      end
    end
  endtask

  // One bus cycle starting at a falling edge; rd is the data for offset o (state before the edge).
  task automatic cycle(input bit wr, input logic [11:0] o, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp_rd;
    wr_en = wr; off = o; wdata = d;
    exp_rd = model_read(o);
`ifndef NVDLA_CDMA_SREG_RDPIPE_EN
    #1 rd = rdata;
`endif
    @(negedge clk);
`ifdef NVDLA_CDMA_SREG_RDPIPE_EN
    rd = rdata;
`endif
    wr_en = 1'b0;
    model_edge(wr, o, d);
    check($sformatf("rd_%03h", o), rd, exp_rd);
    check("arb_weight", {24'd0, arb_weight}, 32'((m_lw[1] << 4) | m_lw[0]));
    check("arb_wmb", {24'd0, arb_wmb}, 32'((m_lm[1] << 4) | m_lm[0]));
    check("producer", {31'd0, producer}, 32'(m_prod));
    check("flush_req", {31'd0, flush_req}, {31'd0, m_freq});
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] offs [12];
    logic [11:0] o;
    bit          w;
    offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014,
             12'h020, 12'h024, 12'h028, 12'h018, 12'h040, 12'hFFC};
    rstn = 1'b0; off = 12'd0; wr_en = 1'b0; wdata = 32'd0;
    status = 4'd0; consumer = 1'b0; flush_done = 1'b0; arb_idle = 1'b0;

    // Reset state
    do_reset();
    check("rst_weight", {24'd0, arb_weight}, 32'h000000FF);
    check("rst_producer", {31'd0, producer}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    cycle(1'b0, 12'h020, 32'd0, rd);
    check("rst_rd_020", rd, 32'h0003000F);

    // Shadowed arbiter write, applied once idle
    cycle(1'b1, 12'h024, 32'h00050002, rd);
    cycle(1'b0, 12'h024, 32'd0, rd);
    check("shadow_rd_024", rd, 32'h00050002);
    check("live_w1_held", {28'd0, arb_weight[7:4]}, 32'h0000000F);
    cycle(1'b0, 12'h014, 32'd0, rd);
    check("pending_set", rd, 32'd1);
    arb_idle = 1'b1;
    cycle(1'b0, 12'h008, 32'd0, rd);
    check("applied_w1", {28'd0, arb_weight[7:4]}, 32'h00000002);
    check("applied_m1", {28'd0, arb_wmb[7:4]}, 32'h00000005);
    cycle(1'b0, 12'h014, 32'd0, rd);
    check("pending_clr", rd, 32'd0);
    arb_idle = 1'b0;

    // Flush handshake and done sticky
    cycle(1'b1, 12'h00C, 32'h2, rd);
    check("flush_req_set", {31'd0, flush_req}, 32'd1);
    flush_done = 1'b1;
    cycle(1'b0, 12'h00C, 32'd0, rd);
    check("flush_req_clr", {31'd0, flush_req}, 32'd0);
    cycle(1'b0, 12'h00C, 32'd0, rd);
    check("flush_rd", rd, 32'h5);
    check("flush_irq", {31'd0, irq}, 32'd1);
    cycle(1'b1, 12'h00C, 32'h4, rd);
    cycle(1'b0, 12'h000, 32'd0, rd);
    check("flush_irq_clr", {31'd0, irq}, 32'd0);
    flush_done = 1'b0;

    // Error stickies
    cycle(1'b1, 12'h000, 32'hFFFFFFFF, rd);
    cycle(1'b1, 12'h040, 32'h12345678, rd);
    cycle(1'b0, 12'h010, 32'd0, rd);
    check("err_rd", rd, 32'h00400003);
    check("err_irq", {31'd0, irq}, 32'd1);
    cycle(1'b1, 12'h010, 32'h3, rd);
    cycle(1'b0, 12'h010, 32'd0, rd);
    check("err_clr_rd", rd, 32'h00400000);

    // Write on the apply edge: live gets the older shadow, pending stays set
    cycle(1'b1, 12'h024, 32'h00070001, rd);
    arb_idle = 1'b1;
    cycle(1'b1, 12'h024, 32'h00090004, rd);
    check("coinc_live_old", {28'd0, arb_weight[7:4]}, 32'h00000001);
    cycle(1'b0, 12'h014, 32'd0, rd);
    check("coinc_pending", rd, 32'd1);
    check("coinc_live_new", {28'd0, arb_weight[7:4]}, 32'h00000004);
    arb_idle = 1'b0;

    // Pointer
    consumer = 1'b1;
    cycle(1'b1, 12'h004, 32'h00000001, rd);
    cycle(1'b0, 12'h004, 32'd0, rd);
    check("ptr_rd", rd, 32'h00010001);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      status     = 4'($urandom);
      consumer   = 1'($urandom);
      arb_idle   = ($urandom_range(0, 2) == 0);
      flush_done = ($urandom_range(0, 3) == 0) ? ~flush_done : flush_done;
      o = ($urandom_range(0, 12) == 12) ? 12'($urandom) : offs[$urandom_range(0, 11)];
      w = ($urandom_range(0, 1) == 1);
      cycle(w, o, $urandom, rd);
    end

    // Reset mid-operation drops a pending shadow value
    arb_idle = 1'b0;
    cycle(1'b1, 12'h020, 32'h00010001, rd);
    do_reset();
    cycle(1'b0, 12'h014, 32'd0, rd);
    check("mid_rst_pending", rd, 32'd0);
    cycle(1'b0, 12'h020, 32'd0, rd);
    check("mid_rst_rd_020", rd, 32'h0003000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
